seq_mul64: RTL and testbench



---
 rtl/mul_pkg.sv | 12 +
 rtl/seq_mul64_if.sv | 23 ++
 rtl/mul_step_r4.sv | 25 ++
 rtl/seq_mul64.sv | 91 +++++++++
 tb/tb_seq_mul64.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential 64x64 radix-4 multiplier.
package mul_pkg;
  localparam int MUL_W     = 64;
  localparam int MUL_ITERS = 32;
  localparam int MUL_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;
endpackage

// File: rtl/seq_mul64_if.sv
// Request/response bundle between the execute-stage ALU (master) and seq_mul64 (slave).
interface seq_mul64_if;
  import mul_pkg::*;

  logic             mul_valid;
  logic             flush;
  logic [MUL_W-1:0] multiplicand;
  logic [MUL_W-1:0] multiplier;
  logic             mul_ready;
  logic             out_valid;
  logic [31:0]      result_hi;
  logic [31:0]      result_lo;

  modport master (
    output mul_valid, flush, multiplicand, multiplier,
    input  mul_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  mul_valid, flush, multiplicand, multiplier,
    output mul_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/mul_step_r4.sv
// One radix-4 shift-add step: adds d*A to the accumulator, keeping the low 64 bits.
module mul_step_r4
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0] acc,
  input  logic [MUL_W-1:0] a,
  input  logic [1:0]       d,
  output logic [MUL_W-1:0] acc_next
);
  logic [MUL_W-1:0] term_s;

  // Select the partial product for the current multiplier digit.
  always_comb begin
    term_s = {MUL_W{1'b0}};
    case (d)
      2'd0:    term_s = {MUL_W{1'b0}};
      2'd1:    term_s = a;
      2'd2:    term_s = a << 1;
      2'd3:    term_s = a + (a << 1);
      default: term_s = {MUL_W{1'b0}};
    endcase
  end

  assign acc_next = acc + term_s;
endmodule

// File: rtl/seq_mul64.sv
// Sequential 64x64 multiplier, low 64 product bits, two multiplier bits per cycle.
module seq_mul64
  import mul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  seq_mul64_if.slave    bus
);
  mul_state_e           state_r;
  logic [MUL_W-1:0]     a_r;
  logic [MUL_W-1:0]     b_r;
  logic [MUL_W-1:0]     acc_r;
  logic [MUL_CNT_W-1:0] cnt_r;
  logic                 mul_ready_r;
  logic                 out_valid_r;
  logic [MUL_W-1:0]     result_r;
  logic [MUL_W-1:0]     acc_next_s;

  mul_step_r4 u_step (
    .acc      (acc_r),
    .a        (a_r),
    .d        (b_r[1:0]),
    .acc_next (acc_next_s)
  );

  // Control FSM with operand, accumulator, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= {MUL_W{1'b0}};
      b_r         <= {MUL_W{1'b0}};
      acc_r       <= {MUL_W{1'b0}};
      cnt_r       <= {MUL_CNT_W{1'b0}};
      mul_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {MUL_W{1'b0}};
    end else if (bus.flush) begin
      // Abandon whatever is in flight; result registers stay untouched.
      state_r     <= IDLE;
      cnt_r       <= {MUL_CNT_W{1'b0}};
      mul_ready_r <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          if (bus.mul_valid) begin
            a_r         <= bus.multiplicand;
            b_r         <= bus.multiplier;
            acc_r       <= {MUL_W{1'b0}};
            cnt_r       <= {MUL_CNT_W{1'b0}};
            mul_ready_r <= 1'b0;
            state_r     <= BUSY;
          end else begin
            mul_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        BUSY: begin
          acc_r <= acc_next_s;
          a_r   <= a_r << 2;
          b_r   <= b_r >> 2;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'(MUL_ITERS - 1)) begin
            result_r    <= acc_next_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r     <= BUSY;
          end
        end
        DONE: begin
          out_valid_r <= 1'b0;
          mul_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          out_valid_r <= 1'b0;
          mul_ready_r <= 1'b1;
          cnt_r       <= {MUL_CNT_W{1'b0}};
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.mul_ready = mul_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result_hi = result_r[63:32];
  assign bus.result_lo = result_r[31:0];
endmodule

// File: tb/tb_seq_mul64.sv
// Directed self-checking bench for seq_mul64: latency, wrap, busy-ignore, flush, reset, throughput.
module tb_seq_mul64;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  seq_mul64_if bus ();

  seq_mul64 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, optionally inject valid/flush/rst at negedge ev_cycle, observe for 40 cycles.
  // Negedge i lies in the cycle after accept edge E(i-1); a pulse raised at E32 is seen at i=33.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int ev_cycle,
                        input logic ev_valid, input logic ev_flush, input logic ev_rst,
                        output logic [63:0] prod, output int first_pulse, output int pulses,
                        output logic rdy_acc, output logic rdy_post,
                        output logic rdy_ev, output logic ov_ev);
    prod        = {bus.result_hi, bus.result_lo};
    first_pulse = -1;
    pulses      = 0;
    rdy_acc     = 1'b1;
    rdy_post    = 1'b0;
    rdy_ev      = 1'b0;
    ov_ev       = 1'b1;
    @(negedge clk);
    bus.mul_valid    = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      bus.mul_valid = 1'b0;
      bus.flush     = 1'b0;
      rst           = 1'b0;
      if (i == 1) begin
        rdy_acc          = bus.mul_ready;
        bus.multiplicand = 64'd9;
        bus.multiplier   = 64'd9;
      end
      if (i == ev_cycle + 1) begin
        rdy_ev = bus.mul_ready;
        ov_ev  = bus.out_valid;
      end
      if (first_pulse >= 0 && i == first_pulse + 1) rdy_post = bus.mul_ready;
      if (bus.out_valid) begin
        pulses++;
        if (first_pulse < 0) begin
          first_pulse = i;
          prod        = {bus.result_hi, bus.result_lo};
        end
      end
      if (i == ev_cycle) begin
        bus.mul_valid = ev_valid;
        bus.flush     = ev_flush;
        rst           = ev_rst;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mul_valid = 1'b0;
    bus.flush = 1'b0;
    bus.multiplicand = 64'd0;
    bus.multiplier = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.mul_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.result_hi !== 32'd0 || bus.result_lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b ov=%b hi=%h lo=%h, required 1 0 0 0",
               bus.mul_ready, bus.out_valid, bus.result_hi, bus.result_lo);
    end
  endtask

  task automatic test_basic();
    logic [63:0] p; int fp, np; logic ra, rp, re, oe;
    run_op(64'd3, 64'd5, 0, 1'b0, 1'b0, 1'b0, p, fp, np, ra, rp, re, oe);
    tests_run++;
    if (p !== 64'h0000_0000_0000_000F) begin
      tests_failed++; $display("FAIL basic_product: got %h, required 000000000000000f", p);
    end
    tests_run++;
    if (ra !== 1'b0) begin
      tests_failed++; $display("FAIL basic_ready_low: got %b, required 0", ra);
    end
    tests_run++;
    if (fp !== 33 || np !== 1) begin
      tests_failed++; $display("FAIL basic_latency: pulse at %0d count %0d, required 33 and 1", fp, np);
    end
    tests_run++;
    if (rp !== 1'b1) begin
      tests_failed++; $display("FAIL basic_ready_after: got %b, required 1", rp);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] va [0:3];
    logic [63:0] vb [0:3];
    logic [63:0] ve [0:3];
    logic [63:0] p; int fp, np; logic ra, rp, re, oe;
    va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'hFFFF_FFFF_FFFF_FFFF; ve[0] = 64'h0000_0000_0000_0001;
    va[1] = 64'h8000_0000_0000_0000; vb[1] = 64'd2;                   ve[1] = 64'h0;
    va[2] = 64'h0000_0001_0000_0000; vb[2] = 64'h0000_0001_0000_0000; ve[2] = 64'h0;
    va[3] = 64'h0000_0000_FFFF_FFFF; vb[3] = 64'h0000_0000_FFFF_FFFF; ve[3] = 64'hFFFF_FFFE_0000_0001;
    for (int k = 0; k < 4; k++) begin
      run_op(va[k], vb[k], 0, 1'b0, 1'b0, 1'b0, p, fp, np, ra, rp, re, oe);
      tests_run++;
      if (p !== ve[k] || np !== 1) begin
        tests_failed++;
        $display("FAIL wrap_%0d: got %h (pulses %0d), required %h (pulses 1)", k, p, np, ve[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, e, p; int fp, np; logic ra, rp, re, oe;
    for (int k = 0; k < 16; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      e = a * b;
      run_op(a, b, 0, 1'b0, 1'b0, 1'b0, p, fp, np, ra, rp, re, oe);
      tests_run++;
      if (p !== e) begin
        tests_failed++;
        $display("FAIL random_%0d: %h*%h got %h, required %h", k, a, b, p, e);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [63:0] p; int fp, np; logic ra, rp, re, oe;
    run_op(64'd7, 64'd6, 10, 1'b1, 1'b0, 1'b0, p, fp, np, ra, rp, re, oe);
    tests_run++;
    if (p !== 64'd42 || np !== 1 || fp !== 33) begin
      tests_failed++;
      $display("FAIL busy_ignore: got %0d pulses %0d at %0d, required 42 pulses 1 at 33", p, np, fp);
    end
  endtask

  task automatic test_flush();
    logic [63:0] p; int fp, np; logic ra, rp, re, oe;
    run_op(64'd12, 64'd12, 15, 1'b0, 1'b1, 1'b0, p, fp, np, ra, rp, re, oe);
    tests_run++;
    if (np !== 0 || re !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_abort: pulses %0d ready %b, required 0 pulses ready 1", np, re);
    end
    tests_run++;
    if ({bus.result_hi, bus.result_lo} !== 64'd42) begin
      tests_failed++;
      $display("FAIL flush_hold: got %h, required 000000000000002a", {bus.result_hi, bus.result_lo});
    end
    @(negedge clk);
    bus.mul_valid = 1'b1;
    bus.flush = 1'b1;
    bus.multiplicand = 64'd5;
    bus.multiplier = 64'd5;
    @(negedge clk);
    bus.mul_valid = 1'b0;
    bus.flush = 1'b0;
    tests_run++;
    if (bus.mul_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_vs_valid: ready %b, required 1 (request rejected)", bus.mul_ready);
    end
    np = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) np++;
    end
    tests_run++;
    if (np !== 0) begin
      tests_failed++;
      $display("FAIL flush_vs_valid_pulse: got %0d pulses, required 0", np);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] p; int fp, np; logic ra, rp, re, oe;
    run_op(64'd12, 64'd3, 20, 1'b0, 1'b0, 1'b1, p, fp, np, ra, rp, re, oe);
    tests_run++;
    if (re !== 1'b1 || oe !== 1'b0 || np !== 0 ||
        bus.result_hi !== 32'd0 || bus.result_lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: ready %b ov %b pulses %0d hi %h lo %h, required 1 0 0 0 0",
               re, oe, np, bus.result_hi, bus.result_lo);
    end
    run_op(64'd2, 64'd21, 0, 1'b0, 1'b0, 1'b0, p, fp, np, ra, rp, re, oe);
    tests_run++;
    if (p !== 64'd42) begin
      tests_failed++; $display("FAIL reset_fresh: got %0d, required 42", p);
    end
  endtask

  task automatic test_back_to_back();
    int pulse_at [0:3];
    int n;
    logic [63:0] p;
    n = 0;
    p = 64'd0;
    @(negedge clk);
    bus.mul_valid = 1'b1;
    bus.multiplicand = 64'd11;
    bus.multiplier = 64'd13;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (n < 4) pulse_at[n] = i;
        n++;
        p = {bus.result_hi, bus.result_lo};
      end
    end
    bus.mul_valid = 1'b0;
    tests_run++;
    if (n !== 3) begin
      tests_failed++; $display("FAIL b2b_count: got %0d pulses, required 3", n);
    end else begin
      tests_run++;
      if (pulse_at[0] !== 33 || pulse_at[1] - pulse_at[0] !== 34 || pulse_at[2] - pulse_at[1] !== 34) begin
        tests_failed++;
        $display("FAIL b2b_spacing: pulses at %0d %0d %0d, required 33 67 101",
                 pulse_at[0], pulse_at[1], pulse_at[2]);
      end
    end
    tests_run++;
    if (p !== 64'd143) begin
      tests_failed++; $display("FAIL b2b_product: got %0d, required 143", p);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_busy_ignore();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
